mr_scoreboard: RTL and testbench

- Issue-interlock controller for the decode stage.
- Tracks register writes that decode has issued but writeback has not yet committed.
- Holds decode (issue_ready low) on RAW or WAW hazards, or when the in-flight limit is reached.
- Sits between ifetch/decode handshake and the WB return path; releases a hazard once the matching writeback has reached the register file.

---
 rtl/mr_scoreboard_pkg.sv | 17 +
 rtl/mr_sb_counter.sv | 48 ++++
 rtl/mr_scoreboard.sv | 117 +++++++++++
 tb/tb_mr_scoreboard.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mr_scoreboard_pkg.sv
// Shared configuration for the mr_scoreboard issue interlock: register-file
// geometry, default counter width / in-flight limit and an x0 helper.
package mr_scoreboard_pkg;

  localparam int REG_ADDR_W       = 5;
  localparam int NUM_ARCH_REGS    = 32;
  localparam int CNT_W_DEF        = 2;
  localparam int MAX_INFLIGHT_DEF = 4;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // x0 is hardwired to zero, so it never carries a pending write
  function automatic logic is_tracked(input reg_addr_t r);
    return (r != {REG_ADDR_W{1'b0}});
  endfunction

endpackage

// File: rtl/mr_sb_counter.sv
// Per-register pending-write counter: saturating up/down with synchronous
// clear; a decrement at zero is ignored so the count never underflows.
module mr_sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic nonzero_o,
  output logic sat_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             up_s;
  logic             down_s;

  assign nonzero_o = (cnt_q != {CNT_W{1'b0}});
  assign sat_o     = (cnt_q == {CNT_W{1'b1}});
  assign up_s      = inc_i && !sat_o;
  assign down_s    = dec_i && nonzero_o;

  // Next count: clear wins; a matched inc/dec pair cancels out
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (up_s && !down_s) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (down_s && !up_s) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mr_scoreboard.sv
// Decode-stage issue interlock: tracks writes issued but not yet written back
// and holds issue on RAW, WAW saturation or when the in-flight limit is hit.
module mr_scoreboard
  import mr_scoreboard_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              id_req,
  input  logic [REG_ADDR_W-1:0]             id_rs1,
  input  logic                              id_rs1_used,
  input  logic [REG_ADDR_W-1:0]             id_rs2,
  input  logic                              id_rs2_used,
  input  logic [REG_ADDR_W-1:0]             id_rd,
  input  logic                              id_rd_wr,
  output logic                              issue_ready,
  input  logic                              wb_valid,
  input  logic [REG_ADDR_W-1:0]             wb_reg,
  input  logic                              flush,
  output logic                              busy,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic                              err
);

  localparam int IW = $clog2(MAX_INFLIGHT+1);

  logic [NUM_ARCH_REGS-1:0] nz_s;
  logic [NUM_ARCH_REGS-1:0] sat_s;
  logic                     ready_s;
  logic                     fire_wr_s;
  logic                     wb_hit_s;
  logic                     wb_dec_s;
  logic                     wb_err_s;
  logic [IW-1:0]            inflight_q;
  logic [IW-1:0]            inflight_d;
  logic                     busy_q;
  logic                     busy_d;
  logic                     err_q;
  logic                     err_d;

  assign nz_s[0]  = 1'b0;
  assign sat_s[0] = 1'b0;

  for (genvar i = 1; i < NUM_ARCH_REGS; i++) begin : g_cnt
    mr_sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (flush),
      .inc_i     (fire_wr_s && (id_rd == REG_ADDR_W'(i))),
      .dec_i     (wb_valid && (wb_reg == REG_ADDR_W'(i))),
      .nonzero_o (nz_s[i]),
      .sat_o     (sat_s[i])
    );
  end

  // Hazard check against pre-writeback state: no same-cycle bypass
  always_comb begin
    ready_s = 1'b1;
    if (rst || flush) begin
      ready_s = 1'b0;
    end else if ((id_rs1_used && nz_s[id_rs1]) || (id_rs2_used && nz_s[id_rs2])) begin
      ready_s = 1'b0;
    end else if (id_rd_wr && is_tracked(id_rd) &&
                 (sat_s[id_rd] || (inflight_q == IW'(MAX_INFLIGHT)))) begin
      ready_s = 1'b0;
    end else begin
      ready_s = 1'b1;
    end
  end

  assign issue_ready = ready_s;
  assign fire_wr_s   = id_req && ready_s && id_rd_wr && is_tracked(id_rd);
  assign wb_hit_s    = wb_valid && is_tracked(wb_reg);
  assign wb_dec_s    = wb_hit_s && nz_s[wb_reg];
  assign wb_err_s    = wb_hit_s && !nz_s[wb_reg];

  // Total in-flight count, error flag and busy next state
  always_comb begin
    inflight_d = inflight_q;
    err_d      = err_q;
    if (flush) begin
      inflight_d = {IW{1'b0}};
    end else if (fire_wr_s && !wb_dec_s) begin
      inflight_d = inflight_q + {{(IW-1){1'b0}}, 1'b1};
    end else if (wb_dec_s && !fire_wr_s) begin
      inflight_d = inflight_q - {{(IW-1){1'b0}}, 1'b1};
    end else begin
      inflight_d = inflight_q;
    end
    if (wb_err_s && !flush) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
    busy_d = (inflight_d != {IW{1'b0}});
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= {IW{1'b0}};
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign inflight = inflight_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mr_scoreboard.sv
// Self-checking bench for mr_scoreboard: directed scenarios followed by random
// traffic, all compared against a per-register pending-count reference model.
module tb_mr_scoreboard;

  localparam int MAXI = 4;
  localparam int SATC = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_req;
  logic [4:0] id_rs1;
  logic       id_rs1_used;
  logic [4:0] id_rs2;
  logic       id_rs2_used;
  logic [4:0] id_rd;
  logic       id_rd_wr;
  logic       issue_ready;
  logic       wb_valid;
  logic [4:0] wb_reg;
  logic       flush;
  logic       busy;
  logic [2:0] inflight;
  logic       err;

  int n_vec = 0;
  int n_bad = 0;

  int pend [32];
  int m_infl;
  int m_err;

  mr_scoreboard #(.CNT_W(2), .MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .rst(rst), .id_req(id_req), .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_rd_wr(id_rd_wr),
    .issue_ready(issue_ready), .wb_valid(wb_valid), .wb_reg(wb_reg), .flush(flush),
    .busy(busy), .inflight(inflight), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_ready();
    if (rst || flush) return 0;
    if (id_rs1_used && id_rs1 != 0 && pend[id_rs1] != 0) return 0;
    if (id_rs2_used && id_rs2 != 0 && pend[id_rs2] != 0) return 0;
    if (id_rd_wr && id_rd != 0 && pend[id_rd] == SATC) return 0;
    if (id_rd_wr && id_rd != 0 && m_infl == MAXI) return 0;
    return 1;
  endfunction

  // One cycle: drive, check readiness, advance the model, check state
  task automatic step(input bit r, input bit req, input int rs1, input bit u1,
                      input int rs2, input bit u2, input int rd, input bit wr,
                      input bit wbv, input int wbr, input bit fl);
    int er;
    @(negedge clk);
    rst = r; id_req = req; id_rs1 = 5'(rs1); id_rs1_used = u1;
    id_rs2 = 5'(rs2); id_rs2_used = u2; id_rd = 5'(rd); id_rd_wr = wr;
    wb_valid = wbv; wb_reg = 5'(wbr); flush = fl;
    #1;
    er = exp_ready();
    chk("issue_ready", int'(issue_ready), er);
    @(posedge clk);
    if (r) begin
      foreach (pend[k]) pend[k] = 0;
      m_infl = 0;
      m_err  = 0;
    end else if (fl) begin
      foreach (pend[k]) pend[k] = 0;
      m_infl = 0;
    end else begin
      if (wbv && wbr != 0) begin
        if (pend[wbr] > 0) begin
          pend[wbr]--;
          m_infl--;
        end else begin
          m_err = 1;
        end
      end
      if (req && er == 1 && wr && rd != 0) begin
        pend[rd]++;
        m_infl++;
      end
    end
    #1;
    chk("inflight", int'(inflight), m_infl);
    chk("busy", int'(busy), (m_infl != 0) ? 1 : 0);
    chk("err", int'(err), m_err);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    foreach (pend[k]) pend[k] = 0;
    m_infl = 0;
    m_err  = 0;
    rst = 1'b1; id_req = 1'b0; id_rs1 = 5'd0; id_rs1_used = 1'b0; id_rs2 = 5'd0;
    id_rs2_used = 1'b0; id_rd = 5'd0; id_rd_wr = 1'b0; wb_valid = 1'b0; wb_reg = 5'd0;
    flush = 1'b0;

    // reset, then a clean read-only issue
    step(1, 1, 5, 1, 6, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 5, 1, 6, 1, 0, 0, 0, 0, 0);
    chk("plan1_ready_seen", m_infl, 0);

    // RAW on x3 released the cycle after writeback
    step(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    step(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 3, 1, 0, 0, 0, 0, 1, 3, 0);
    step(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("plan2_released", int'(issue_ready), 1);

    // WAW saturation on x7
    repeat (4) step(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    chk("plan3_sat_count", pend[7], 3);
    step(0, 1, 0, 0, 0, 0, 7, 1, 1, 7, 0);
    step(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0);

    // capacity limit, non-writing and x0 writes still issue
    for (int r = 1; r <= 5; r++) step(0, 1, 0, 0, 0, 0, r, 1, 0, 0, 0);
    chk("plan4_cap", int'(inflight), 4);
    step(0, 1, 10, 1, 11, 1, 6, 0, 0, 0, 0);
    step(0, 1, 10, 1, 11, 1, 0, 1, 0, 0, 0);
    for (int r = 1; r <= 4; r++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, r, 0);

    // same-cycle fire and writeback on x9
    step(0, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 9, 1, 1, 9, 0);
    chk("plan5_pend9", pend[9], 1);

    // stray writeback sets sticky err; flush keeps it; reset clears it
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 0);
    step(0, 1, 0, 0, 0, 0, 13, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 14, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 14, 1, 1, 13, 1);
    idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // random traffic over a small register window
    for (int c = 0; c < 3000; c++) begin
      bit r_b, fl_b;
      r_b  = ($urandom_range(0, 199) == 0);
      fl_b = ($urandom_range(0, 39) == 0);
      step(r_b, 1'($urandom_range(0, 3) != 0),
           $urandom_range(0, 7), 1'($urandom_range(0, 1)),
           $urandom_range(0, 7), 1'($urandom_range(0, 1)),
           $urandom_range(0, 7), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 2) == 0), $urandom_range(0, 7), fl_b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
